// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a five-stage pipeline. It arbitrates memory waits, multi-cycle
// mul/div, fetch misses, taken branches and load-use hazards into per-register hold/flush strobes.
module pipeline_hazard_controller #(
    parameter int unsigned MULDIV_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        imem_busywait_i,
    input  logic        dmem_busywait_i,
    input  logic        load_use_hazard_i,
    input  logic        muldiv_start_i,
    input  logic        branch_taken_i,
    output logic        pc_hold_o,
    output logic        if_id_hold_o,
    output logic        id_ex_hold_o,
    output logic        ex_mem_hold_o,
    output logic        mem_wb_hold_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_count_o
);

    // state    | meaning
    // RUN      | normal issue; hazards resolved combinationally
    // MEM_WAIT | data memory stall entered from RUN
    // MULDIV   | front end held while the mul/div unit iterates
    // FLUSH    | branch redirect waiting on instruction memory
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_MULDIV   = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

    state_t      state_q, state_d;
    state_t      eval_state;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [15:0] stall_q, stall_d;
    logic        md_start;

    // The cycle that releases a data-memory wait is treated exactly like RUN.
    assign eval_state = (state_q == S_MEM_WAIT) ? S_RUN : state_q;
    assign md_start   = muldiv_start_i && !done_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= S_RUN;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        stall_d = (pc_hold_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        if (dmem_busywait_i) begin
            if (state_q == S_RUN) begin
                state_d = S_MEM_WAIT;
            end
        end else begin
            case (eval_state)
                S_RUN: begin
                    done_d  = 1'b0;
                    state_d = S_RUN;
                    if (md_start) begin
                        state_d = S_MULDIV;
                        cnt_d   = MD_LOAD;
                    end else if (imem_busywait_i && branch_taken_i) begin
                        state_d = S_FLUSH;
                    end
                end
                S_MULDIV: begin
                    if (cnt_q <= 8'd1) begin
                        state_d = S_RUN;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_FLUSH: begin
                    if (!imem_busywait_i) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_comb begin
        pc_hold_o      = 1'b0;
        if_id_hold_o   = 1'b0;
        id_ex_hold_o   = 1'b0;
        ex_mem_hold_o  = 1'b0;
        mem_wb_hold_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        if (!reset_i || dmem_busywait_i) begin
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_hold_o  = 1'b1;
            ex_mem_hold_o = 1'b1;
            mem_wb_hold_o = 1'b1;
        end else begin
            case (eval_state)
                S_RUN: begin
                    if (md_start) begin
                        pc_hold_o      = 1'b1;
                        if_id_hold_o   = 1'b1;
                        id_ex_hold_o   = 1'b1;
                        ex_mem_flush_o = 1'b1;
                    end else if (imem_busywait_i && !branch_taken_i) begin
                        pc_hold_o     = 1'b1;
                        if_id_flush_o = 1'b1;
                    end else if (branch_taken_i) begin
                        pc_hold_o     = imem_busywait_i;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (load_use_hazard_i) begin
                        pc_hold_o     = 1'b1;
                        if_id_hold_o  = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
                S_MULDIV: begin
                    pc_hold_o      = 1'b1;
                    if_id_hold_o   = 1'b1;
                    id_ex_hold_o   = 1'b1;
                    ex_mem_flush_o = 1'b1;
                end
                S_FLUSH: begin
                    pc_hold_o     = imem_busywait_i;
                    if_id_flush_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o       = state_q;
    assign stall_count_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench: the driver queues hand-written expected outputs per cycle,
// and an independent monitor pops and compares them at each falling edge.
module tb_pipeline_hazard_controller;

    logic        clk_i = 1'b0;
    logic        reset_i, imem_i, dmem_i, lu_i, ms_i, br_i;
    logic        pc_h, ifid_h, idex_h, exmem_h, memwb_h;
    logic        ifid_f, idex_f, exmem_f;
    logic [1:0]  state_o;
    logic [15:0] stall_count_o;

    typedef struct packed {
        logic [4:0]  h;
        logic [2:0]  f;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          vec    = 0;
    logic [15:0] exp_cnt;

    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_MD = 2'd2, S_FL = 2'd3;
    // hold = {pc, if_id, id_ex, ex_mem, mem_wb}; flush = {if_id, id_ex, ex_mem}
    localparam logic [4:0] HA = 5'b11111, HM = 5'b11100, HP = 5'b10000, HL = 5'b11000, H0 = 5'b00000;
    localparam logic [2:0] F0 = 3'b000, FX = 3'b001, FI = 3'b100, FB = 3'b110, FLU = 3'b010;

    pipeline_hazard_controller #(.MULDIV_CYCLES(8)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .imem_busywait_i   (imem_i),
        .dmem_busywait_i   (dmem_i),
        .load_use_hazard_i (lu_i),
        .muldiv_start_i    (ms_i),
        .branch_taken_i    (br_i),
        .pc_hold_o         (pc_h),
        .if_id_hold_o      (ifid_h),
        .id_ex_hold_o      (idex_h),
        .ex_mem_hold_o     (exmem_h),
        .mem_wb_hold_o     (memwb_h),
        .if_id_flush_o     (ifid_f),
        .id_ex_flush_o     (idex_f),
        .ex_mem_flush_o    (exmem_f),
        .state_o           (state_o),
        .stall_count_o     (stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   idx = 0;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("hold",  idx, {11'd0, pc_h, ifid_h, idex_h, exmem_h, memwb_h}, {11'd0, e.h});
                chk("flush", idx, {13'd0, ifid_f, idex_f, exmem_f}, {13'd0, e.f});
                chk("state", idx, {14'd0, state_o}, {14'd0, e.st});
                chk("stall_count", idx, stall_count_o, e.cnt);
                idx++;
            end
        end
    end

    task automatic cyc(input logic rst, dm, im, lu, ms, br,
                       input logic [4:0] h, input logic [2:0] f, input logic [1:0] st);
        exp_t e;
        reset_i = rst; dmem_i = dm; imem_i = im; lu_i = lu; ms_i = ms; br_i = br;
        e.h = h; e.f = f; e.st = st; e.cnt = exp_cnt;
        sb_q.push_back(e);
        vec++;
        if (!rst) exp_cnt = 16'd0;
        else if (h[4] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic [1:0] st);
        cyc(1, 0, 0, 0, 0, 0, H0, F0, st);
    endtask

    initial begin : driver
        reset_i = 1'b0; dmem_i = 0; imem_i = 0; lu_i = 0; ms_i = 0; br_i = 0;
        exp_cnt = 16'd0;
        repeat (2) @(posedge clk_i);
        #1;
        cyc(0, 1, 1, 1, 1, 1, HA, F0, S_RUN);
        idle(S_RUN);

        // mul/div with start held through the release cycle: 8 stalls, no retrigger
        cyc(1, 0, 0, 0, 1, 0, HM, FX, S_RUN);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 1, 0, HM, FX, S_MD);
        cyc(1, 0, 0, 0, 1, 0, H0, F0, S_RUN);
        idle(S_RUN);

        // data-memory stall in the middle of mul/div freezes the counter
        cyc(1, 0, 0, 0, 1, 0, HM, FX, S_RUN);
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 0, HM, FX, S_MD);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1, 0, HA, F0, S_MD);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0, HM, FX, S_MD);
        cyc(1, 0, 0, 0, 1, 0, H0, F0, S_RUN);
        idle(S_RUN);

        // taken branch during a fetch miss
        cyc(1, 0, 1, 0, 0, 1, HP, FB, S_RUN);
        cyc(1, 0, 1, 0, 0, 1, HP, FI, S_FL);
        cyc(1, 0, 0, 0, 0, 0, H0, FI, S_FL);
        idle(S_RUN);

        // plain fetch miss, load-use, load-use with branch
        cyc(1, 0, 1, 0, 0, 0, HP, FI, S_RUN);
        idle(S_RUN);
        cyc(1, 0, 0, 1, 0, 0, HL, FLU, S_RUN);
        cyc(1, 0, 0, 1, 0, 1, H0, FB, S_RUN);
        idle(S_RUN);

        // MEM_WAIT entry and release cycle evaluated as RUN
        cyc(1, 1, 0, 0, 0, 0, HA, F0, S_RUN);
        cyc(1, 1, 1, 1, 1, 1, HA, F0, S_MW);
        cyc(1, 0, 0, 1, 0, 0, HL, FLU, S_MW);
        idle(S_RUN);

        // reset aborts mul/div, flush and memory wait
        cyc(1, 0, 0, 0, 1, 0, HM, FX, S_RUN);
        cyc(1, 0, 0, 0, 1, 0, HM, FX, S_MD);
        cyc(0, 0, 0, 0, 1, 0, HA, F0, S_MD);
        cyc(0, 0, 0, 0, 1, 0, HA, F0, S_RUN);
        idle(S_RUN);
        cyc(1, 0, 1, 0, 0, 1, HP, FB, S_RUN);
        cyc(0, 0, 1, 0, 0, 0, HA, F0, S_FL);
        idle(S_RUN);
        cyc(1, 1, 0, 0, 0, 0, HA, F0, S_RUN);
        cyc(0, 1, 0, 0, 0, 0, HA, F0, S_MW);
        idle(S_RUN);

        // drive the stall counter up to its ceiling with fetch misses
        for (int i = 0; i < 65534; i++) begin
            reset_i = 1; imem_i = 1; dmem_i = 0; lu_i = 0; ms_i = 0; br_i = 0;
            @(posedge clk_i);
            #1;
        end
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, HP, FI, S_RUN);
        idle(S_RUN);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_drained", vec, 16'(sb_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MULDIV_CYCLES, default 8, total stall cycles for a mul/div op; legal range 2..255.
REQ-002 CLK  input  1  system clock; all state updates on posedge.
REQ-003 RESET  input  1  synchronous, active-low reset; RESET=0 at a posedge resets the block.
REQ-004 IMEM_BUSYWAIT  input  1  instruction memory not ready.
REQ-005 DMEM_BUSYWAIT  input  1  data memory not ready.
REQ-006 LOAD_USE_HAZARD  input  1  ID-stage instruction needs a load result still in EX.
REQ-007 MULDIV_START  input  1  EX stage holds a mul/div op.
REQ-008 BRANCH_TAKEN  input  1  EX resolved a taken branch or jump.
REQ-009 PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD  output  1 each  drive the BUSYWAIT input of the PC and pipeline registers; 1 = keep value.
REQ-010 IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  output  1 each  load a NOP bubble into that register.
REQ-011 STATE  output  2  current FSM state: RUN=0, MEM_WAIT=1, MULDIV=2, FLUSH=3.
REQ-012 STALL_COUNT  output  16  count of cycles with PC_HOLD=1.

Function
REQ-013 STATE and STALL_COUNT SHALL be registered; hold/flush outputs SHALL be combinational from STATE, counter and inputs.
REQ-014 Unlisted hold/flush outputs are 0; a register never has HOLD and FLUSH both 1.
REQ-015 Priority: DMEM_BUSYWAIT > MULDIV > IMEM_BUSYWAIT > BRANCH_TAKEN > LOAD_USE_HAZARD.
REQ-016 DMEM_BUSYWAIT=1, any state: all five HOLD=1, all FLUSH=0, mul/div counter frozen, STATE unchanged except RUN -> MEM_WAIT.
REQ-017 MEM_WAIT -> RUN on first cycle DMEM_BUSYWAIT=0; that cycle is evaluated as RUN.
REQ-018 RUN, MULDIV_START=1, done flag 0: PC/IF_ID/ID_EX HOLD=1, EX_MEM_FLUSH=1; counter loads MULDIV_CYCLES-1; next STATE=MULDIV.
REQ-019 MULDIV: same outputs as REQ-018; counter decrements per unfrozen cycle; at counter=1 the next STATE=RUN; stall totals exactly MULDIV_CYCLES cycles absent DMEM stalls.
REQ-020 Done flag SHALL set on MULDIV -> RUN and clear after one RUN cycle; MULDIV_START is ignored while set.
REQ-021 RUN, IMEM_BUSYWAIT=1, BRANCH_TAKEN=0: PC_HOLD=1, IF_ID_FLUSH=1, later stages advance.
REQ-022 RUN, BRANCH_TAKEN=1: IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC not held; if IMEM_BUSYWAIT=1 as well, PC_HOLD=1 and next STATE=FLUSH.
REQ-023 FLUSH: IF_ID_FLUSH=1, PC_HOLD=IMEM_BUSYWAIT; -> RUN when IMEM_BUSYWAIT=0.
REQ-024 RUN, LOAD_USE_HAZARD=1, no higher-priority event: PC_HOLD=1, IF_ID_HOLD=1, ID_EX_FLUSH=1 for one cycle; no state change.
REQ-025 LOAD_USE_HAZARD and BRANCH_TAKEN together: branch wins, no hold.
REQ-026 STALL_COUNT increments each posedge with PC_HOLD=1, saturating at 16'hFFFF.

Reset
REQ-027 RESET=0 at posedge: STATE=RUN, counter=0, done flag=0, STALL_COUNT=0.
REQ-028 While RESET=0: all HOLD=1, all FLUSH=0, inputs ignored.
REQ-029 Reset during MULDIV, MEM_WAIT or FLUSH aborts that operation; no residual stall after release.
REQ-030 First cycle with RESET=1 is evaluated as RUN.

Verification
REQ-031 MULDIV_START=1 held 10 cycles, MULDIV_CYCLES=8 -> PC_HOLD=1 exactly 8 cycles, STATE 0->2->0, no retrigger, STALL_COUNT=8.
REQ-032 DMEM_BUSYWAIT=1 3 cycles mid-MULDIV -> all HOLD=1 for those 3 cycles, total PC_HOLD=11, STATE stays 2.
REQ-033 BRANCH_TAKEN=1 with IMEM_BUSYWAIT=1 2 cycles -> IF_ID_FLUSH=1 both cycles, ID_EX_FLUSH=1 first cycle only, STATE 0->3->0.
REQ-034 LOAD_USE_HAZARD=1 one cycle -> PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1 one cycle; with BRANCH_TAKEN=1 same cycle -> PC_HOLD=0.
REQ-035 RESET=0 in 3rd MULDIV cycle -> next cycle STATE=0, STALL_COUNT=0, all HOLD=1 until RESET=1.
REQ-036 Force STALL_COUNT to 16'hFFFE, 3 stall cycles -> reads 16'hFFFF.
